adc_level_mon: RTL and testbench

Parametrised ADC level and overflow monitor for the receiver front end. It replaces the single-threshold level counter and 64k-sample overflow detector with N independent magnitude thresholds. Each threshold has its own alarm limit, and the block adds a fixed-length measurement window, snapshot registers, an optional peak hold and a window-done event. It runs entirely in the `adc_clk` domain; the ecpu side reaches it through the existing freeze/sync path that produces `cfg_*` and `rd_addr`.

---
 rtl/adc_level_mon_pkg.sv | 26 ++
 rtl/adc_mon_thresh.sv | 62 ++++++
 rtl/adc_level_mon.sv | 200 ++++++++++++++++++++
 tb/tb_adc_level_mon.sv | 380 ++++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/adc_level_mon_pkg.sv
// Shared constants for the ADC level monitor: config/read address map,
// ctrl bit positions and the widest window counter type.
package adc_level_mon_pkg;

    localparam logic [4:0] ADC_MON_CTRL      = 5'd0;
    localparam logic [4:0] ADC_MON_OVFL_MASK = 5'd1;
    localparam logic [4:0] ADC_MON_LEVEL0    = 5'd2;
    localparam logic [4:0] ADC_MON_LIMIT0    = 5'd3;

    localparam logic [3:0] ADC_MON_RD_STATUS = 4'd0;
    localparam logic [3:0] ADC_MON_RD_OVFL   = 4'd1;
    localparam logic [3:0] ADC_MON_RD_PEAK   = 4'd2;
    localparam logic [3:0] ADC_MON_RD_CNT0   = 4'd3;

    localparam int ADC_MON_CTRL_EN  = 0;
    localparam int ADC_MON_CTRL_CLR = 1;

    // Window counters are WIN_BITS+1 wide; this holds the largest (WIN_BITS=24).
    localparam int ADC_MON_CNT_W = 25;
    typedef logic [ADC_MON_CNT_W-1:0] adc_mon_cnt_t;

    function automatic logic [31:0] adc_mon_rd_word(input adc_mon_cnt_t v);
        return 32'(v);
    endfunction

endpackage

// File: rtl/adc_mon_thresh.sv
// One threshold channel: level/limit config, live hit count, window snapshot
// and the registered alarm derived from the closing count.
module adc_mon_thresh
    import adc_level_mon_pkg::*;
#(
    parameter int MAG_BITS = 13,
    parameter int WIN_BITS = 16
) (
    input  logic                adc_clk,
    input  logic                rst_n,
    input  logic                i_level_wr,
    input  logic [MAG_BITS:0]   i_level_data,
    input  logic                i_limit_wr,
    input  logic [WIN_BITS:0]   i_limit_data,
    input  logic [MAG_BITS-1:0] i_mag,
    input  logic                i_acc,
    input  logic                i_last,
    input  logic                i_clear,
    output logic [WIN_BITS:0]   o_snap,
    output logic                o_alarm
);

    // Level is one bit wider than mag so the all-ones reset value never hits.
    logic [MAG_BITS:0] r_level;
    logic [WIN_BITS:0] r_limit;
    logic [WIN_BITS:0] r_cnt;
    logic [WIN_BITS:0] r_snap;
    logic              r_alarm;
    logic              w_hit;
    logic [WIN_BITS:0] w_cnt_next;

    assign w_hit      = ({1'b0, i_mag} >= r_level);
    assign w_cnt_next = r_cnt + {{WIN_BITS{1'b0}}, w_hit};

    always_ff @(posedge adc_clk or negedge rst_n) begin
        if (!rst_n) begin
            r_level <= '1;
            r_limit <= '1;
            r_cnt   <= '0;
            r_snap  <= '0;
            r_alarm <= 1'b0;
        end else begin
            if (i_level_wr) r_level <= i_level_data;
            if (i_limit_wr) r_limit <= i_limit_data;
            if (i_clear) begin
                r_cnt <= '0;
            end else if (i_acc) begin
                if (i_last) begin
                    r_snap  <= w_cnt_next;
                    r_alarm <= (w_cnt_next > r_limit);
                    r_cnt   <= '0;
                end else begin
                    r_cnt <= w_cnt_next;
                end
            end
        end
    end

    assign o_snap  = r_snap;
    assign o_alarm = r_alarm;

endmodule

// File: rtl/adc_level_mon.sv
// ADC level/overflow monitor: N magnitude thresholds over a 2^WIN_BITS sample
// window with snapshots. Optional peak hold under `ADC_LEVEL_MON_PEAK_EN`.
module adc_level_mon
    import adc_level_mon_pkg::*;
#(
    parameter int ADC_BITS = 14,
    parameter int N_THRESH = 4,
    parameter int WIN_BITS = 16
) (
    input  logic                adc_clk,
    input  logic                rst_n,
    input  logic [ADC_BITS-1:0] adc_data,
    input  logic                adc_ovfl,
    input  logic                in_valid,
    input  logic                cfg_wr,
    input  logic [4:0]          cfg_addr,
    input  logic [31:0]         cfg_data,
    input  logic [3:0]          rd_addr,
    output logic [31:0]         rd_data,
    output logic                win_done,
    output logic [N_THRESH-1:0] alarm,
    output logic                ovfl_flag
);

    localparam int MAG_BITS = ADC_BITS - 1;

    logic [MAG_BITS-1:0] w_mag;
    logic [MAG_BITS-1:0] w_neg;
    logic [MAG_BITS-1:0] r_mag;
    logic                r_ovfl_s1;
    logic                r_valid_s1;

    logic                r_enable;
    logic [WIN_BITS:0]   r_ovfl_mask;
    logic [WIN_BITS-1:0] r_samp_cnt;
    logic [WIN_BITS:0]   r_ovfl_cnt;
    logic [WIN_BITS:0]   r_ovfl_snap;
    logic [WIN_BITS:0]   w_ovfl_next;
    logic                r_ovfl_flag;
    logic                r_win_done;
    logic [31:0]         r_rd_data;
    logic [31:0]         w_rd_next;
    logic [31:0]         w_peak_rd;

    logic                w_ctrl_wr;
    logic                w_clear;
    logic                w_acc;
    logic                w_last;
    logic                w_unused_cfg;

    logic [WIN_BITS:0]   w_snap [N_THRESH];
    logic [N_THRESH-1:0] w_alarm;
    adc_mon_cnt_t        w_cnt_ext [N_THRESH];
    adc_mon_cnt_t        w_ovfl_ext;

    // For a negative code the low bits alone give |x| = 2^(n-1) - low; low==0
    // is the most negative code, which saturates instead of wrapping to 0.
    assign w_neg = '0 - adc_data[MAG_BITS-1:0];

    always_comb begin
        w_mag = adc_data[MAG_BITS-1:0];
        if (adc_data[ADC_BITS-1]) begin
            if (adc_data[MAG_BITS-1:0] == '0) w_mag = '1;
            else                              w_mag = w_neg;
        end
    end

    always_ff @(posedge adc_clk or negedge rst_n) begin
        if (!rst_n) begin
            r_mag      <= '0;
            r_ovfl_s1  <= 1'b0;
            r_valid_s1 <= 1'b0;
        end else begin
            r_mag      <= w_mag;
            r_ovfl_s1  <= adc_ovfl;
            r_valid_s1 <= in_valid;
        end
    end

    assign w_ctrl_wr    = cfg_wr && (cfg_addr == ADC_MON_CTRL);
    assign w_clear      = w_ctrl_wr && cfg_data[ADC_MON_CTRL_CLR];
    assign w_acc        = r_valid_s1 && r_enable && !w_clear;
    assign w_last       = w_acc && (&r_samp_cnt);
    assign w_ovfl_next  = r_ovfl_cnt + {{WIN_BITS{1'b0}}, r_ovfl_s1};
    assign w_unused_cfg = ^cfg_data;

    always_ff @(posedge adc_clk or negedge rst_n) begin
        if (!rst_n) begin
            r_enable    <= 1'b0;
            r_ovfl_mask <= '0;
            r_samp_cnt  <= '0;
            r_ovfl_cnt  <= '0;
            r_ovfl_snap <= '0;
            r_ovfl_flag <= 1'b0;
            r_win_done  <= 1'b0;
        end else begin
            if (w_ctrl_wr) r_enable <= cfg_data[ADC_MON_CTRL_EN];
            if (cfg_wr && (cfg_addr == ADC_MON_OVFL_MASK)) r_ovfl_mask <= cfg_data[WIN_BITS:0];
            r_win_done <= w_last;
            if (w_clear) begin
                r_samp_cnt <= '0;
                r_ovfl_cnt <= '0;
            end else if (w_acc) begin
                // Sample counter wraps to 0 on the closing sample by itself.
                r_samp_cnt <= r_samp_cnt + {{(WIN_BITS-1){1'b0}}, 1'b1};
                if (w_last) begin
                    r_ovfl_snap <= w_ovfl_next;
                    r_ovfl_flag <= |(w_ovfl_next & r_ovfl_mask);
                    r_ovfl_cnt  <= '0;
                end else begin
                    r_ovfl_cnt <= w_ovfl_next;
                end
            end
        end
    end

`ifdef ADC_LEVEL_MON_PEAK_EN
    logic [MAG_BITS-1:0] r_peak;
    logic [MAG_BITS-1:0] r_peak_snap;
    logic [MAG_BITS-1:0] w_peak_next;

    assign w_peak_next = (r_mag > r_peak) ? r_mag : r_peak;

    always_ff @(posedge adc_clk or negedge rst_n) begin
        if (!rst_n) begin
            r_peak      <= '0;
            r_peak_snap <= '0;
        end else if (w_clear) begin
            r_peak <= '0;
        end else if (w_acc) begin
            if (w_last) begin
                r_peak_snap <= w_peak_next;
                r_peak      <= '0;
            end else begin
                r_peak <= w_peak_next;
            end
        end
    end

    assign w_peak_rd = 32'(r_peak_snap);
`else
    assign w_peak_rd = '0;
`endif

    genvar gi;
    generate
        for (gi = 0; gi < N_THRESH; gi++) begin : g_thr
            adc_mon_thresh #(
                .MAG_BITS (MAG_BITS),
                .WIN_BITS (WIN_BITS)
            ) u_thr (
                .adc_clk      (adc_clk),
                .rst_n        (rst_n),
                .i_level_wr   (cfg_wr && (cfg_addr == 5'(ADC_MON_LEVEL0 + 2*gi))),
                .i_level_data (cfg_data[MAG_BITS:0]),
                .i_limit_wr   (cfg_wr && (cfg_addr == 5'(ADC_MON_LIMIT0 + 2*gi))),
                .i_limit_data (cfg_data[WIN_BITS:0]),
                .i_mag        (r_mag),
                .i_acc        (w_acc),
                .i_last       (w_last),
                .i_clear      (w_clear),
                .o_snap       (w_snap[gi]),
                .o_alarm      (w_alarm[gi])
            );
        end
    endgenerate

    always_comb begin
        w_ovfl_ext = '0;
        w_ovfl_ext[WIN_BITS:0] = r_ovfl_snap;
        for (int k = 0; k < N_THRESH; k++) begin
            w_cnt_ext[k] = '0;
            w_cnt_ext[k][WIN_BITS:0] = w_snap[k];
        end
    end

    always_comb begin
        w_rd_next = '0;
        case (rd_addr)
            ADC_MON_RD_STATUS: w_rd_next = 32'({r_ovfl_flag, w_alarm});
            ADC_MON_RD_OVFL:   w_rd_next = adc_mon_rd_word(w_ovfl_ext);
            ADC_MON_RD_PEAK:   w_rd_next = w_peak_rd;
            default:           w_rd_next = '0;
        endcase
        for (int k = 0; k < N_THRESH; k++) begin
            if (rd_addr == 4'(ADC_MON_RD_CNT0 + k)) w_rd_next = adc_mon_rd_word(w_cnt_ext[k]);
        end
    end

    always_ff @(posedge adc_clk or negedge rst_n) begin
        if (!rst_n) r_rd_data <= '0;
        else        r_rd_data <= w_rd_next;
    end

    assign rd_data   = r_rd_data;
    assign win_done  = r_win_done;
    assign alarm     = w_alarm;
    assign ovfl_flag = r_ovfl_flag;

endmodule

// File: tb/tb_adc_level_mon.sv
// Randomised bench for adc_level_mon (WIN_BITS=8) with a window-level reference model.
module tb_adc_level_mon;

    localparam int AB  = 14;
    localparam int NT  = 4;
    localparam int WB  = 8;
    localparam int WIN = 1 << WB;

    logic          clk = 1'b0;
    logic          rst_n;
    logic [AB-1:0] adc_data;
    logic          adc_ovfl, in_valid, cfg_wr;
    logic [4:0]    cfg_addr;
    logic [31:0]   cfg_data;
    logic [3:0]    rd_addr;
    logic [31:0]   rd_data;
    logic          win_done;
    logic [NT-1:0] alarm;
    logic          ovfl_flag;

    adc_level_mon #(.ADC_BITS(AB), .N_THRESH(NT), .WIN_BITS(WB)) dut (
        .adc_clk   (clk),
        .rst_n     (rst_n),
        .adc_data  (adc_data),
        .adc_ovfl  (adc_ovfl),
        .in_valid  (in_valid),
        .cfg_wr    (cfg_wr),
        .cfg_addr  (cfg_addr),
        .cfg_data  (cfg_data),
        .rd_addr   (rd_addr),
        .rd_data   (rd_data),
        .win_done  (win_done),
        .alarm     (alarm),
        .ovfl_flag (ovfl_flag)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_pass   = 0;
    int cyc      = 0;
    int done_cnt = 0;
    int done_cyc = -1;

    always @(posedge clk) cyc <= cyc + 1;
    always @(negedge clk) if (win_done === 1'b1) begin done_cnt++; done_cyc = cyc; end

    // Reference model: config, samples of the open window, last closed window.
    int m_level [NT];
    int m_limit [NT];
    int m_mask;
    bit m_en;
    int q_mag[$];
    bit q_ov[$];
    int e_cnt [NT];
    bit e_alarm [NT];
    int e_ovfl, e_peak, e_done, e_close_cyc;
    bit e_flag;
    logic [31:0] rd_v [16];

    function automatic int mag_of(int v);
        int m;
        m = (v < 0) ? -v : v;
        return (m > (1 << (AB-1)) - 1) ? (1 << (AB-1)) - 1 : m;
    endfunction

    function automatic int to_signed(int raw);
        return (raw >= (1 << (AB-1))) ? raw - (1 << AB) : raw;
    endfunction

    task automatic model_reset();
        for (int k = 0; k < NT; k++) begin
            m_level[k] = (1 << AB) - 1; m_limit[k] = (1 << (WB+1)) - 1;
            e_cnt[k] = 0; e_alarm[k] = 0;
        end
        m_mask = 0; m_en = 0; e_ovfl = 0; e_peak = 0; e_flag = 0;
        q_mag.delete(); q_ov.delete();
    endtask

    task automatic model_close();
        for (int k = 0; k < NT; k++) e_cnt[k] = 0;
        e_ovfl = 0; e_peak = 0;
        foreach (q_mag[i]) begin
            for (int k = 0; k < NT; k++) if (q_mag[i] >= m_level[k]) e_cnt[k]++;
            if (q_ov[i]) e_ovfl++;
            if (q_mag[i] > e_peak) e_peak = q_mag[i];
        end
        for (int k = 0; k < NT; k++) e_alarm[k] = (e_cnt[k] > m_limit[k]);
        e_flag = ((e_ovfl & m_mask) != 0);
        e_done++;
        e_close_cyc = cyc;
        q_mag.delete(); q_ov.delete();
        $display("window %0d closed: cnt=%0d/%0d/%0d/%0d ovfl=%0d peak=%0d flag=%0b",
                 e_done, e_cnt[0], e_cnt[1], e_cnt[2], e_cnt[3], e_ovfl, e_peak, e_flag);
    endtask

    function automatic logic [31:0] exp_rd(int a);
        logic [31:0] v;
        v = '0;
        if (a == 0) begin
            for (int k = 0; k < NT; k++) v[k] = e_alarm[k];
            v[NT] = e_flag;
        end else if (a == 1) v = e_ovfl;
`ifdef ADC_LEVEL_MON_PEAK_EN
        else if (a == 2) v = e_peak;
`endif
        else if (a >= 3 && a < 3 + NT) v = e_cnt[a-3];
        return v;
    endfunction

    task automatic tick();
        @(posedge clk); #1;
    endtask

    task automatic idle(int n);
        for (int i = 0; i < n; i++) tick();
    endtask

    task automatic send(int v, bit ov, bit vld, bit track);
        adc_data = v[AB-1:0]; adc_ovfl = ov; in_valid = vld;
        if (track && vld && m_en) begin
            q_mag.push_back(mag_of(v)); q_ov.push_back(ov);
            if (q_mag.size() == WIN) model_close();
        end
        tick();
        in_valid = 1'b0; adc_ovfl = 1'b0;
    endtask

    task automatic cfg(int addr, int data);
        cfg_wr = 1'b1; cfg_addr = addr[4:0]; cfg_data = data;
        if (addr == 0) begin
            m_en = data[0];
            if (data[1]) begin q_mag.delete(); q_ov.delete(); end
        end else if (addr == 1) m_mask = data & ((1 << (WB+1)) - 1);
        else if (addr >= 2 && addr < 2 + 2*NT) begin
            if (addr[0] == 1'b0) m_level[(addr-2)/2] = data & ((1 << AB) - 1);
            else                 m_limit[(addr-3)/2] = data & ((1 << (WB+1)) - 1);
        end
        tick();
        cfg_wr = 1'b0;
    endtask

    task automatic read_all();
        for (int a = 0; a < 16; a++) begin
            rd_addr = a[3:0];
            tick();
            rd_v[a] = rd_data;
        end
    endtask

    task automatic rand_samples(int n);
        for (int i = 0; i < n; i++)
            send(to_signed($urandom_range(0, (1 << AB) - 1)), ($urandom_range(0, 7) == 0), 1'b1, 1'b1);
    endtask

    task automatic test_reset();
        n_checks++; if (win_done !== 1'b0) $display("FAIL reset_win_done: got %b want 0", win_done); else n_pass++;
        n_checks++; if (alarm !== '0) $display("FAIL reset_alarm: got %b want 0", alarm); else n_pass++;
        n_checks++; if (ovfl_flag !== 1'b0) $display("FAIL reset_ovfl_flag: got %b want 0", ovfl_flag); else n_pass++;
        n_checks++; if (rd_data !== '0) $display("FAIL reset_rd_data: got %h want 0", rd_data); else n_pass++;
        rst_n = 1'b1;
        idle(2);
        read_all();
        for (int a = 0; a < 16; a++) begin
            n_checks++;
            if (rd_v[a] !== 32'd0) $display("FAIL reset_rd[%0d]: got %h want 0", a, rd_v[a]); else n_pass++;
        end
    endtask

    task automatic test_plan_window();
        bit hit [WIN];
        int nh;
        logic [31:0] st;
        cfg(0, 3); cfg(2, 100); cfg(3, 10);
        idle(2);
        for (int i = 0; i < WIN; i++) hit[i] = 0;
        nh = 0;
        while (nh < 11) begin
            int p;
            p = $urandom_range(0, WIN-1);
            if (!hit[p]) begin hit[p] = 1; nh++; end
        end
        for (int i = 0; i < WIN; i++) send(hit[i] ? 100 : 0, 1'b0, 1'b1, 1'b1);
        idle(3);
        n_checks++; if (done_cnt !== e_done) $display("FAIL plan_done_count: got %0d want %0d", done_cnt, e_done); else n_pass++;
        n_checks++; if (done_cyc !== e_close_cyc + 2) $display("FAIL plan_done_latency: got cyc %0d want %0d", done_cyc, e_close_cyc + 2); else n_pass++;
        st = exp_rd(0);
        n_checks++; if (alarm !== st[NT-1:0]) $display("FAIL plan_alarm: got %b want %b", alarm, st[NT-1:0]); else n_pass++;
        read_all();
        n_checks++; if (rd_v[3] !== 32'd11) $display("FAIL plan_cnt0: got %0d want 11", rd_v[3]); else n_pass++;
        n_checks++; if (rd_v[0][0] !== 1'b1) $display("FAIL plan_alarm0: got %b want 1", rd_v[0][0]); else n_pass++;
        for (int a = 0; a < 16; a++) begin
            n_checks++;
            if (rd_v[a] !== exp_rd(a)) $display("FAIL plan_rd[%0d]: got %h want %h", a, rd_v[a], exp_rd(a)); else n_pass++;
        end
    endtask

    task automatic test_negmin();
        logic [31:0] pk;
        cfg(0, 3); cfg(4, 8191);
        idle(2);
        for (int i = 0; i < WIN; i++) begin
            int v;
            v = (i == 0) ? -8192 : (i == 5) ? 8190 : int'($urandom_range(0, 100)) - 50;
            send(v, 1'b0, 1'b1, 1'b1);
        end
        idle(3);
        n_checks++; if (done_cnt !== e_done) $display("FAIL negmin_done_count: got %0d want %0d", done_cnt, e_done); else n_pass++;
        read_all();
        n_checks++; if (rd_v[4] !== 32'd1) $display("FAIL negmin_cnt1: got %0d want 1", rd_v[4]); else n_pass++;
        pk = exp_rd(2);
        n_checks++; if (rd_v[2] !== pk) $display("FAIL negmin_peak: got %0d want %0d", rd_v[2], pk); else n_pass++;
        for (int a = 0; a < 16; a++) begin
            n_checks++;
            if (rd_v[a] !== exp_rd(a)) $display("FAIL negmin_rd[%0d]: got %h want %h", a, rd_v[a], exp_rd(a)); else n_pass++;
        end
    endtask

    task automatic test_ovfl();
        int masks [2] = '{2, 4};
        bit flags [2] = '{1'b1, 1'b0};
        for (int r = 0; r < 2; r++) begin
            cfg(1, masks[r]); cfg(0, 3);
            idle(1);
            for (int i = 0; i < WIN; i++) send(0, (i == 10 || i == 100 || i == 200), 1'b1, 1'b1);
            idle(3);
            n_checks++; if (ovfl_flag !== flags[r]) $display("FAIL ovfl_flag_mask%0d: got %b want %b", masks[r], ovfl_flag, flags[r]); else n_pass++;
            n_checks++; if (ovfl_flag !== e_flag) $display("FAIL ovfl_flag_model%0d: got %b want %b", masks[r], ovfl_flag, e_flag); else n_pass++;
            read_all();
            n_checks++; if (rd_v[1] !== 32'd3) $display("FAIL ovfl_cnt_mask%0d: got %0d want 3", masks[r], rd_v[1]); else n_pass++;
            n_checks++; if (rd_v[0] !== exp_rd(0)) $display("FAIL ovfl_status_mask%0d: got %h want %h", masks[r], rd_v[0], exp_rd(0)); else n_pass++;
        end
    endtask

    task automatic test_random();
        for (int r = 0; r < 3; r++) begin
            int target, guard;
            for (int k = 0; k < NT; k++) begin
                cfg(2 + 2*k, $urandom_range(0, (1 << (AB-1)) - 1));
                cfg(3 + 2*k, $urandom_range(0, WIN));
            end
            cfg(1, $urandom_range(0, (1 << (WB+1)) - 1));
            cfg(0, 3);
            idle(1);
            target = e_done + 1;
            guard = 0;
            while (e_done < target && guard < 2000) begin
                send(to_signed($urandom_range(0, (1 << AB) - 1)), ($urandom_range(0, 5) == 0),
                     ($urandom_range(0, 3) != 0), 1'b1);
                guard++;
            end
            idle(3);
            n_checks++; if (done_cnt !== e_done) $display("FAIL rand%0d_done_count: got %0d want %0d", r, done_cnt, e_done); else n_pass++;
            n_checks++; if (done_cyc !== e_close_cyc + 2) $display("FAIL rand%0d_done_latency: got %0d want %0d", r, done_cyc, e_close_cyc + 2); else n_pass++;
            read_all();
            for (int a = 0; a < 3 + NT; a++) begin
                n_checks++;
                if (rd_v[a] !== exp_rd(a)) $display("FAIL rand%0d_rd[%0d]: got %h want %h", r, a, rd_v[a], exp_rd(a)); else n_pass++;
            end
        end
    endtask

    task automatic test_half_rate();
        int guard;
        cfg(0, 3);
        idle(1);
        guard = 0;
        while (q_mag.size() < WIN - 1 && guard < 1000) begin
            send(to_signed($urandom_range(0, (1 << AB) - 1)), 1'b0, 1'b1, 1'b1);
            send(0, 1'b0, 1'b0, 1'b1);
            guard += 2;
        end
        n_checks++; if (done_cnt !== e_done) $display("FAIL half_early_done: got %0d want %0d", done_cnt, e_done); else n_pass++;
        send(1234, 1'b0, 1'b1, 1'b1);
        idle(3);
        n_checks++; if (done_cnt !== e_done) $display("FAIL half_done_count: got %0d want %0d", done_cnt, e_done); else n_pass++;
        n_checks++; if (done_cyc !== e_close_cyc + 2) $display("FAIL half_done_latency: got %0d want %0d", done_cyc, e_close_cyc + 2); else n_pass++;
    endtask

    task automatic test_clear_on_close();
        int d0;
        cfg(0, 3);
        idle(1);
        rand_samples(WIN - 1);
        send(77, 1'b0, 1'b1, 1'b0);
        cfg(0, 3);
        d0 = done_cnt;
        idle(3);
        n_checks++; if (done_cnt !== d0) $display("FAIL clear_close_done: got %0d want %0d", done_cnt, d0); else n_pass++;
        read_all();
        for (int a = 0; a < 3 + NT; a++) begin
            n_checks++;
            if (rd_v[a] !== exp_rd(a)) $display("FAIL clear_hold_rd[%0d]: got %h want %h", a, rd_v[a], exp_rd(a)); else n_pass++;
        end
        rand_samples(WIN - 1);
        idle(3);
        n_checks++; if (done_cnt !== d0) $display("FAIL clear_short_window: got %0d want %0d", done_cnt, d0); else n_pass++;
        rand_samples(1);
        idle(3);
        n_checks++; if (done_cnt !== e_done) $display("FAIL clear_full_window: got %0d want %0d", done_cnt, e_done); else n_pass++;
        n_checks++; if (done_cyc !== e_close_cyc + 2) $display("FAIL clear_full_latency: got %0d want %0d", done_cyc, e_close_cyc + 2); else n_pass++;
    endtask

    task automatic test_disable_close();
        int d0;
        cfg(0, 3);
        idle(1);
        rand_samples(WIN);
        cfg(0, 0);
        idle(3);
        n_checks++; if (done_cnt !== e_done) $display("FAIL disable_close_done: got %0d want %0d", done_cnt, e_done); else n_pass++;
        read_all();
        for (int a = 0; a < 3 + NT; a++) begin
            n_checks++;
            if (rd_v[a] !== exp_rd(a)) $display("FAIL disable_close_rd[%0d]: got %h want %h", a, rd_v[a], exp_rd(a)); else n_pass++;
        end
        d0 = done_cnt;
        rand_samples(WIN + 40);
        idle(3);
        n_checks++; if (done_cnt !== d0) $display("FAIL disabled_frozen: got %0d want %0d", done_cnt, d0); else n_pass++;
    endtask

    task automatic test_reset_mid();
        cfg(2, 0); cfg(3, 0); cfg(0, 3);
        idle(1);
        rand_samples(WIN);
        idle(3);
        n_checks++; if (alarm[0] !== 1'b1) $display("FAIL pre_reset_alarm0: got %b want 1", alarm[0]); else n_pass++;
        rand_samples(100);
        #3 rst_n = 1'b0;
        model_reset();
        #1;
        n_checks++; if (alarm !== '0) $display("FAIL async_reset_alarm: got %b want 0", alarm); else n_pass++;
        n_checks++; if (rd_data !== '0) $display("FAIL async_reset_rd_data: got %h want 0", rd_data); else n_pass++;
        n_checks++; if (ovfl_flag !== 1'b0 || win_done !== 1'b0) $display("FAIL async_reset_flags: got %b%b want 00", ovfl_flag, win_done); else n_pass++;
        @(posedge clk); #1 rst_n = 1'b1;
        idle(2);
        read_all();
        for (int a = 0; a < 16; a++) begin
            n_checks++;
            if (rd_v[a] !== 32'd0) $display("FAIL post_reset_rd[%0d]: got %h want 0", a, rd_v[a]); else n_pass++;
        end
        cfg(0, 1);
        idle(1);
        for (int i = 0; i < WIN; i++) send(int'($urandom_range(0, 16000)) - 8000, ($urandom_range(0, 3) == 0), 1'b1, 1'b1);
        idle(3);
        n_checks++; if (alarm !== '0 || ovfl_flag !== 1'b0) $display("FAIL post_reset_alarms: got %b/%b want 0/0", alarm, ovfl_flag); else n_pass++;
        read_all();
        for (int a = 0; a < 3 + NT; a++) begin
            n_checks++;
            if (rd_v[a] !== exp_rd(a)) $display("FAIL post_reset_rd_win[%0d]: got %h want %h", a, rd_v[a], exp_rd(a)); else n_pass++;
        end
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        rst_n = 1'b0; adc_data = '0; adc_ovfl = 1'b0; in_valid = 1'b0;
        cfg_wr = 1'b0; cfg_addr = '0; cfg_data = '0; rd_addr = '0;
        e_done = 0; e_close_cyc = -1;
        model_reset();
        idle(3);
        test_reset();
        test_plan_window();
        test_negmin();
        test_ovfl();
        test_random();
        test_half_rate();
        test_clear_on_close();
        test_disable_close();
        test_reset_mid();
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
